mod_reduce_seq: RTL

Bit-serial modular reducer that sits directly downstream of the Karatsuba multiplier in the modular-multiplication path. It consumes the `2*width`-bit product `ab` together with the multiplier's `done` pulse and produces `r = ab mod p` for a runtime modulus `p`. The algorithm is restoring shift-subtract, one product bit per clock, using a single `width+1`-bit compare/subtract. The MSM datapath then receives a fully reduced field element plus its own completion pulse.

---
 rtl/mod_reduce_if.sv | 22 ++
 rtl/mod_reduce_seq.sv | 122 ++++++++++++
 2 files changed

// File: rtl/mod_reduce_if.sv
// Handshake/data bundle between the multiplier-side producer and mod_reduce_seq.
interface mod_reduce_if #(
  parameter int width = 128
);
  logic                 enable;
  logic [2*width-1:0]   ab;
  logic [width-1:0]     p;
  logic [width-1:0]     r;
  logic                 done;
  logic                 busy;
  logic                 err;

  modport master (
    output enable, ab, p,
    input  r, done, busy, err
  );

  modport slave (
    input  enable, ab, p,
    output r, done, busy, err
  );
endinterface

// File: rtl/mod_reduce_seq.sv
// Bit-serial restoring shift-subtract reducer: r = ab mod p, one product bit per clock.
// Optional invalid-modulus check (p == 0) is built only when MODRED_PCHECK_EN is defined.
module mod_reduce_seq #(
  parameter int width = 128
) (
  input  logic         clk,
  input  logic         reset,
  mod_reduce_if.slave  bus
);

  localparam int CW = $clog2(2*width) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(2*width - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e               state_q, state_d;
  logic [2*width-1:0]   sh_q, sh_d;
  logic [width-1:0]     p_q, p_d;
  logic [width-1:0]     rem_q, rem_d;
  logic [width-1:0]     r_q, r_d;
  logic [CW-1:0]        cnt_q, cnt_d;
`ifdef MODRED_PCHECK_EN
  logic                 err_q, err_d;
`endif

  logic [width:0]       t;
  logic [width-1:0]     rem_nxt;

  // rem < p_q keeps the true difference below 2^width, so width-bit subtraction is exact.
  always_comb begin
    t       = {rem_q, sh_q[2*width-1]};
    rem_nxt = (t >= {1'b0, p_q}) ? (t[width-1:0] - p_q) : t[width-1:0];
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    p_d     = p_q;
    rem_d   = rem_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
`ifdef MODRED_PCHECK_EN
    err_d   = err_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (bus.enable) begin
          sh_d    = bus.ab;
          p_d     = bus.p;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
`ifdef MODRED_PCHECK_EN
          if (bus.p == '0) begin
            state_d = DONE;
            r_d     = '0;
            err_d   = 1'b1;
          end else begin
            err_d   = 1'b0;
          end
`endif
        end
      end
      RUN: begin
        rem_d = rem_nxt;
        sh_d  = {sh_q[2*width-2:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          r_d     = rem_nxt;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      cnt_q   <= '0;
      r_q     <= '0;
`ifdef MODRED_PCHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
`ifdef MODRED_PCHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  // NOTE: operand registers are always loaded before use, so they carry no reset.
  always_ff @(posedge clk) begin
    sh_q <= sh_d;
    p_q  <= p_d;
  end

  assign bus.r    = r_q;
  assign bus.done = (state_q == DONE);
  assign bus.busy = (state_q != IDLE);
`ifdef MODRED_PCHECK_EN
  assign bus.err  = err_q;
`else
  assign bus.err  = 1'b0;
`endif

endmodule
